// File: rtl/itwd_mul10.sv
// ============================================================================
// Module   : itwd_mul10
// Brief    : IFFT stage-10 twiddle. Multiplies diff path by {1, +j} per beat.
// Options  : ITWD_SAT_EN enables saturating negation and sticky o_ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module itwd_mul10 #(
  parameter int WIDTH     = 12,
  parameter int LANES     = 16,
  parameter int BLK_BEATS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic [WIDTH*LANES-1:0]   i_sum_re,
  input  logic [WIDTH*LANES-1:0]   i_sum_im,
  input  logic [WIDTH*LANES-1:0]   i_diff_re,
  input  logic [WIDTH*LANES-1:0]   i_diff_im,
  output logic                     o_valid,
  output logic                     o_sof,
  output logic [WIDTH*LANES-1:0]   o_sum_re,
  output logic [WIDTH*LANES-1:0]   o_sum_im,
  output logic [WIDTH*LANES-1:0]   o_diff_re,
  output logic [WIDTH*LANES-1:0]   o_diff_im,
  output logic                     o_ovf
);

  localparam int c_blk_len = 2 * BLK_BEATS;
  localparam int c_cnt_w   = $clog2(c_blk_len);

  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_cnt_w-1:0]       w_cnt_cur;
  logic [c_cnt_w-1:0]       w_cnt_nxt;
  logic                     w_seg;
  logic [WIDTH*LANES-1:0]   w_diff_re_nxt;
  logic [WIDTH*LANES-1:0]   w_diff_im_nxt;

  // A valid sof restarts the block at this very beat.
  assign w_cnt_cur = (i_valid && i_sof) ? '0 : r_cnt;
  assign w_seg     = (w_cnt_cur >= c_cnt_w'(BLK_BEATS));
  assign w_cnt_nxt = (w_cnt_cur == c_cnt_w'(c_blk_len - 1)) ? '0 : (w_cnt_cur + c_cnt_w'(1));

`ifdef ITWD_SAT_EN
  logic [LANES-1:0] w_lane_ovf;
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [WIDTH-1:0] w_re;
    logic signed [WIDTH-1:0] w_im;
    logic signed [WIDTH-1:0] w_neg_im;

    assign w_re = i_diff_re[j*WIDTH +: WIDTH];
    assign w_im = i_diff_im[j*WIDTH +: WIDTH];

`ifdef ITWD_SAT_EN
    logic [WIDTH:0] w_neg_full;
    assign w_neg_full    = -{w_im[WIDTH-1], w_im};
    // Only -(-2^(W-1)) lands on +2^(W-1), i.e. top two bits 01.
    assign w_lane_ovf[j] = (w_neg_full[WIDTH:WIDTH-1] == 2'b01);
    assign w_neg_im      = w_lane_ovf[j] ? {1'b0, {(WIDTH-1){1'b1}}} : w_neg_full[WIDTH-1:0];
`else
    assign w_neg_im = -w_im;
`endif

    assign w_diff_re_nxt[j*WIDTH +: WIDTH] = w_seg ? w_neg_im : w_re;
    assign w_diff_im_nxt[j*WIDTH +: WIDTH] = w_seg ? w_re     : w_im;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_sum_re  <= '0;
      o_sum_im  <= '0;
      o_diff_re <= '0;
      o_diff_im <= '0;
    end else begin
      o_valid <= i_valid;
      o_sof   <= i_valid & i_sof;
      if (i_valid) begin
        r_cnt     <= w_cnt_nxt;
        o_sum_re  <= i_sum_re;
        o_sum_im  <= i_sum_im;
        o_diff_re <= w_diff_re_nxt;
        o_diff_im <= w_diff_im_nxt;
      end
    end
  end

`ifdef ITWD_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ovf <= 1'b0;
    end else if (i_valid && w_seg && (|w_lane_ovf)) begin
      o_ovf <= 1'b1;
    end
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

`default_nettype wire
